// File: rtl/bitfusion_operand_feeder_pkg.sv
// Shared types and helpers for the Bit Fusion operand feeder.
// Covers width codes, the FSM state and the held operand-pair payload.
package bitfusion_feeder_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned OP_W       = 8;
  localparam int unsigned CODE_W     = 3;
  localparam int unsigned SHIFT_W    = 4;
  localparam int unsigned BEAT_IDX_W = 2;

  localparam logic [CODE_W-1:0] W1B = CODE_W'(0);
  localparam logic [CODE_W-1:0] W2B = CODE_W'(1);
  localparam logic [CODE_W-1:0] W4B = CODE_W'(2);
  localparam logic [CODE_W-1:0] W8B = CODE_W'(3);

  typedef enum logic {
    IDLE = 1'b0,
    BEAT = 1'b1
  } feeder_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   act;
    logic [OP_W-1:0]   wgt;
    logic [CODE_W-1:0] act_width;
    logic [CODE_W-1:0] wgt_width;
    logic              s_act;
    logic              s_wgt;
    logic              last;
  } op_pair_t;

  // Codes 3..7 all mean a full 8-bit operand.
  function automatic logic is_wide(input logic [CODE_W-1:0] code);
    return code >= W8B;
  endfunction

  // Index of the final beat of a pair: 0, 1 or 3.
  function automatic logic [BEAT_IDX_W-1:0] last_beat_idx(input op_pair_t p);
    logic [BEAT_IDX_W-1:0] idx;
    case ({is_wide(p.act_width), is_wide(p.wgt_width)})
      2'b11:   idx = BEAT_IDX_W'(3);
      2'b00:   idx = BEAT_IDX_W'(0);
      default: idx = BEAT_IDX_W'(1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bitfusion_operand_feeder_if.sv
// Operand-pair input and per-beat output bundle of the operand feeder.
interface bitfusion_operand_feeder_if;
  import bitfusion_feeder_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_in;
  logic [OP_W-1:0]   op_weight;
  logic [CODE_W-1:0] op_in_width;
  logic [CODE_W-1:0] op_weight_width;
  logic              op_s_in;
  logic              op_s_weight;
  logic              op_last;

  logic               out_valid;
  logic [NIB_W-1:0]   out_in;
  logic [NIB_W-1:0]   out_weight;
  logic [CODE_W-1:0]  out_in_width;
  logic [CODE_W-1:0]  out_weight_width;
  logic               out_s_in;
  logic               out_s_weight;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_last;
  logic               psum_capture;

  modport master (
    output op_valid, op_in, op_weight, op_in_width, op_weight_width,
           op_s_in, op_s_weight, op_last,
    input  op_ready, out_valid, out_in, out_weight, out_in_width,
           out_weight_width, out_s_in, out_s_weight, out_shift, out_last,
           psum_capture
  );

  modport slave (
    input  op_valid, op_in, op_weight, op_in_width, op_weight_width,
           op_s_in, op_s_weight, op_last,
    output op_ready, out_valid, out_in, out_weight, out_in_width,
           out_weight_width, out_s_in, out_s_weight, out_shift, out_last,
           psum_capture
  );

endinterface

// File: rtl/bitfusion_operand_feeder_nibble_slicer.sv
// Picks one 4-bit nibble of an operand for a beat, with its beat width code and sign.
module bitfusion_nibble_slicer
  import bitfusion_feeder_pkg::*;
(
  input  logic [OP_W-1:0]   operand,
  input  logic [CODE_W-1:0] width_code,
  input  logic              sign,
  input  logic              nib_idx,
  output logic [NIB_W-1:0]  nibble,
  output logic [CODE_W-1:0] beat_code,
  output logic              beat_sign
);

  logic [NIB_W-1:0] mask;

  // Wide operands split into low (unsigned) and high (signed) halves; narrow ones are masked.
  always_comb begin
    mask      = '1;
    nibble    = operand[NIB_W-1:0];
    beat_code = width_code;
    beat_sign = sign;
    if (is_wide(width_code)) begin
      nibble    = nib_idx ? operand[OP_W-1:NIB_W] : operand[NIB_W-1:0];
      beat_code = W4B;
      beat_sign = nib_idx & sign;
    end else begin
      case (width_code)
        W1B:     mask = NIB_W'(1);
        W2B:     mask = NIB_W'(3);
        default: mask = '1;
      endcase
      nibble = operand[NIB_W-1:0] & mask;
    end
  end

endmodule

// File: rtl/bitfusion_operand_feeder.sv
// Sequences 8-bit operand pairs into 4-bit Bit Fusion beats and
// flags when psum holds a finished dot product.
module bitfusion_operand_feeder
  import bitfusion_feeder_pkg::*;
#(
  parameter int unsigned PSUM_LAT = 3
) (
  input logic                       clk,
  input logic                       rst,
  bitfusion_operand_feeder_if.slave bus
);

  feeder_state_e         state_q, state_d;
  op_pair_t              pair_q, pair_d, incoming, sel;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic                  xfer, drive, last_d, ready_d;
  logic                  nib_i, nib_w;
  logic [SHIFT_W-1:0]    shift_d;

  logic [NIB_W-1:0]      act_nib, wgt_nib;
  logic [CODE_W-1:0]     act_code, wgt_code;
  logic                  act_sign, wgt_sign;

  logic                  ready_q, valid_q, s_in_q, s_wgt_q, last_q;
  logic [NIB_W-1:0]      in_q, wgt_q;
  logic [CODE_W-1:0]     in_width_q, wgt_width_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic [PSUM_LAT-1:0]   cap_sr;

  always_comb begin
    incoming.act       = bus.op_in;
    incoming.wgt       = bus.op_weight;
    incoming.act_width = bus.op_in_width;
    incoming.wgt_width = bus.op_weight_width;
    incoming.s_act     = bus.op_s_in;
    incoming.s_wgt     = bus.op_s_weight;
    incoming.last      = bus.op_last;
  end

  assign xfer = bus.op_valid & ready_q;

  // Next state: a transfer always starts beat 0 of the new pair, otherwise walk the held pair.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    beat_d  = beat_q;
    sel     = pair_q;
    drive   = 1'b0;
    if (xfer) begin
      pair_d  = incoming;
      sel     = incoming;
      beat_d  = '0;
      drive   = 1'b1;
      state_d = (last_beat_idx(incoming) == '0) ? IDLE : BEAT;
    end else if (state_q == BEAT) begin
      if (beat_q == last_beat_idx(pair_q)) begin
        state_d = IDLE;
      end else begin
        beat_d = beat_q + BEAT_IDX_W'(1);
        drive  = 1'b1;
      end
    end
    last_d  = drive & sel.last & (beat_d == last_beat_idx(sel));
    ready_d = (state_d == IDLE) | (beat_d == last_beat_idx(pair_d));
  end

  // Beat order (i,w): (0,0) (1,0) (0,1) (1,1), narrow operands pinned to nibble 0.
  always_comb begin
    nib_i = 1'b0;
    nib_w = 1'b0;
    if (is_wide(sel.act_width)) begin
      nib_i = beat_d[0];
      nib_w = is_wide(sel.wgt_width) & beat_d[1];
    end else begin
      nib_w = is_wide(sel.wgt_width) & beat_d[0];
    end
    shift_d = SHIFT_W'({2'(nib_i) + 2'(nib_w), 2'b00});
  end

  bitfusion_nibble_slicer u_act_slicer (
    .operand    (sel.act),
    .width_code (sel.act_width),
    .sign       (sel.s_act),
    .nib_idx    (nib_i),
    .nibble     (act_nib),
    .beat_code  (act_code),
    .beat_sign  (act_sign)
  );

  bitfusion_nibble_slicer u_wgt_slicer (
    .operand    (sel.wgt),
    .width_code (sel.wgt_width),
    .sign       (sel.s_wgt),
    .nib_idx    (nib_w),
    .nibble     (wgt_nib),
    .beat_code  (wgt_code),
    .beat_sign  (wgt_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pair_q      <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      in_q        <= '0;
      wgt_q       <= '0;
      in_width_q  <= '0;
      wgt_width_q <= '0;
      s_in_q      <= 1'b0;
      s_wgt_q     <= 1'b0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      cap_sr      <= '0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      valid_q     <= drive;
      in_q        <= drive ? act_nib  : '0;
      wgt_q       <= drive ? wgt_nib  : '0;
      in_width_q  <= drive ? act_code : '0;
      wgt_width_q <= drive ? wgt_code : '0;
      s_in_q      <= drive & act_sign;
      s_wgt_q     <= drive & wgt_sign;
      shift_q     <= drive ? shift_d : '0;
      last_q      <= last_d;
      // Delay line matching the fusion unit's psum latency.
      cap_sr      <= PSUM_LAT'({cap_sr, last_q});
    end
  end

  assign bus.op_ready         = ready_q;
  assign bus.out_valid        = valid_q;
  assign bus.out_in           = in_q;
  assign bus.out_weight       = wgt_q;
  assign bus.out_in_width     = in_width_q;
  assign bus.out_weight_width = wgt_width_q;
  assign bus.out_s_in         = s_in_q;
  assign bus.out_s_weight     = s_wgt_q;
  assign bus.out_shift        = shift_q;
  assign bus.out_last         = last_q;
  assign bus.psum_capture     = cap_sr[PSUM_LAT-1];

endmodule

// File: tb/tb_bitfusion_operand_feeder.sv
// Bench for bitfusion_operand_feeder: directed vector table, corner sequences,
// then random traffic against a beat-list reference model.
module tb_bitfusion_operand_feeder;
  import bitfusion_feeder_pkg::*;

  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic [3:0] ni;
    logic [3:0] nw;
    logic [2:0] ci;
    logic [2:0] cw;
    logic       si;
    logic       sw;
    logic [3:0] sh;
  } beat_t;

  typedef struct packed {
    logic [7:0]      a;
    logic [7:0]      w;
    logic [2:0]      ca;
    logic [2:0]      cw;
    logic            sa;
    logic            sw;
    logic [2:0]      nb;
    beat_t [3:0]     b;
  } vec_t;

  typedef struct packed {
    beat_t b;
    logic  last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bitfusion_operand_feeder_if bus ();

  bitfusion_operand_feeder #(.PSUM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t obs_beat();
    beat_t o;
    o.ni = bus.out_in;
    o.nw = bus.out_weight;
    o.ci = bus.out_in_width;
    o.cw = bus.out_weight_width;
    o.si = bus.out_s_in;
    o.sw = bus.out_s_weight;
    o.sh = bus.out_shift;
    return o;
  endfunction

  function automatic beat_t mk(input int ni, input int nw, input int ci, input int cw,
                               input int si, input int sw, input int sh);
    beat_t b;
    b.ni = 4'(ni); b.nw = 4'(nw); b.ci = 3'(ci); b.cw = 3'(cw);
    b.si = 1'(si); b.sw = 1'(sw); b.sh = 4'(sh);
    return b;
  endfunction

  function automatic vec_t mkv(input int a, input int w, input int ca, input int cw,
                               input int sa, input int sw, input int nb,
                               input beat_t b0, input beat_t b1, input beat_t b2, input beat_t b3);
    vec_t v;
    v.a = 8'(a); v.w = 8'(w); v.ca = 3'(ca); v.cw = 3'(cw);
    v.sa = 1'(sa); v.sw = 1'(sw); v.nb = 3'(nb);
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    return v;
  endfunction

  task automatic drive_pair(input logic [7:0] a, input logic [7:0] w, input logic [2:0] ca,
                            input logic [2:0] cw, input logic sa, input logic sw, input logic last);
    bus.op_valid        = 1'b1;
    bus.op_in           = a;
    bus.op_weight       = w;
    bus.op_in_width     = ca;
    bus.op_weight_width = cw;
    bus.op_s_in         = sa;
    bus.op_s_weight     = sw;
    bus.op_last         = last;
  endtask

  task automatic scramble_inputs();
    bus.op_in           = 8'($urandom);
    bus.op_weight       = 8'($urandom);
    bus.op_in_width     = 3'($urandom);
    bus.op_weight_width = 3'($urandom);
    bus.op_s_in         = 1'($urandom);
    bus.op_s_weight     = 1'($urandom);
    bus.op_last         = 1'($urandom);
  endtask

  // Reference model: a pair becomes an ordered list of expected beats.
  exp_t model_q[$];
  logic pipe[$];

  function automatic logic [3:0] nib_of(input logic [7:0] x, input logic [2:0] code, input int idx);
    int v;
    if (code >= 3) v = (int'(x) >> (4 * idx)) & 15;
    else           v = int'(x) & ((1 << (1 << int'(code))) - 1);
    return 4'(v);
  endfunction

  function automatic void expand(input logic [7:0] a, input logic [7:0] w, input logic [2:0] ca,
                                 input logic [2:0] cw, input logic sa, input logic sw, input logic last);
    int ni = (ca >= 3) ? 2 : 1;
    int nw = (cw >= 3) ? 2 : 1;
    for (int j = 0; j < nw; j++) begin
      for (int i = 0; i < ni; i++) begin
        exp_t e;
        e.b.ni = nib_of(a, ca, i);
        e.b.nw = nib_of(w, cw, j);
        e.b.ci = (ca >= 3) ? 3'd2 : ca;
        e.b.cw = (cw >= 3) ? 3'd2 : cw;
        e.b.si = (ca >= 3) ? (sa && i == 1) : sa;
        e.b.sw = (cw >= 3) ? (sw && j == 1) : sw;
        e.b.sh = 4'(4 * (i + j));
        e.last = last && (i == ni - 1) && (j == nw - 1);
        model_q.push_back(e);
      end
    end
  endfunction

  function automatic void model_reset();
    model_q.delete();
    pipe.delete();
    for (int k = 0; k < int'(LAT); k++) pipe.push_back(1'b0);
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int waitc = 0;
    @(negedge clk);
    while (!bus.op_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.op_ready) check($sformatf("vec%0d_ready_timeout", id), 32'(bus.op_ready), 32'd1);
    drive_pair(v.a, v.w, v.ca, v.cw, v.sa, v.sw, 1'b0);
    for (int k = 0; k < int'(v.nb); k++) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
      scramble_inputs();
      check($sformatf("vec%0d_beat%0d", id, k), 32'(obs_beat()), 32'(v.b[k]));
      check($sformatf("vec%0d_valid%0d", id, k), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_ready%0d", id, k), 32'(bus.op_ready), 32'(k == int'(v.nb) - 1));
    end
    @(negedge clk);
    check($sformatf("vec%0d_idle_valid", id), 32'(bus.out_valid), 32'd0);
    check($sformatf("vec%0d_idle_beat", id), 32'(obs_beat()), 32'd0);
  endtask

  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lastbits, psbits;
    vec_t       bb[3];
    exp_t       cur;
    logic       cur_valid;
    logic       exp_last, p, do_rst;

    vt[0] = mkv(8'h0B, 8'h05, 2, 2, 0, 0, 1,
                mk('hB, 'h5, 2, 2, 0, 0, 0), '0, '0, '0);
    vt[1] = mkv(8'hA7, 8'h3C, 3, 3, 0, 0, 4,
                mk('h7, 'hC, 2, 2, 0, 0, 0), mk('hA, 'hC, 2, 2, 0, 0, 4),
                mk('h7, 'h3, 2, 2, 0, 0, 4), mk('hA, 'h3, 2, 2, 0, 0, 8));
    vt[2] = mkv(8'h80, 8'hFF, 3, 1, 1, 1, 2,
                mk('h0, 'h3, 2, 1, 0, 1, 0), mk('h8, 'h3, 2, 1, 1, 1, 4), '0, '0);
    vt[3] = mkv(8'hFF, 8'h12, 0, 2, 0, 0, 1,
                mk('h1, 'h2, 0, 2, 0, 0, 0), '0, '0, '0);
    vt[4] = mkv(8'hFF, 8'h05, 6, 2, 1, 1, 2,
                mk('hF, 'h5, 2, 2, 0, 1, 0), mk('hF, 'h5, 2, 2, 1, 1, 4), '0, '0);
    vt[5] = mkv(8'h03, 8'h9C, 1, 3, 0, 1, 2,
                mk('h3, 'hC, 1, 2, 0, 0, 0), mk('h3, 'h9, 1, 2, 0, 1, 4), '0, '0);
    vt[6] = mkv(8'hFE, 8'h03, 1, 0, 1, 1, 1,
                mk('h2, 'h1, 1, 0, 1, 1, 0), '0, '0, '0);

    rst = 1'b1;
    bus.op_valid = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge clk);
    check("reset_beat", 32'(obs_beat()), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_last", 32'(bus.out_last), 32'd0);
    check("reset_psum", 32'(bus.psum_capture), 32'd0);
    check("reset_ready", 32'(bus.op_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Single-beat pairs stream at one pair per cycle.
    bb[0] = vt[0];
    bb[1] = mkv(8'h73, 8'h2E, 2, 2, 1, 0, 1, mk('h3, 'hE, 2, 2, 1, 0, 0), '0, '0, '0);
    bb[2] = vt[6];
    @(negedge clk);
    drive_pair(bb[0].a, bb[0].w, bb[0].ca, bb[0].cw, bb[0].sa, bb[0].sw, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b_beat%0d", k), 32'(obs_beat()), 32'(bb[k].b[0]));
      check($sformatf("b2b_ready%0d", k), 32'(bus.op_ready), 32'd1);
      if (k < 2) drive_pair(bb[k+1].a, bb[k+1].w, bb[k+1].ca, bb[k+1].cw, bb[k+1].sa, bb[k+1].sw, 1'b0);
      else bus.op_valid = 1'b0;
    end

    // Two op_last pairs back-to-back: out_last in cycles 1,2 and psum_capture in 4,5.
    @(negedge clk);
    lastbits = '0;
    psbits   = '0;
    drive_pair(8'h11, 8'h22, 2, 2, 0, 0, 1'b1);
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      lastbits[c] = bus.out_last;
      psbits[c]   = bus.psum_capture;
      if (c == 1) drive_pair(8'h33, 8'h44, 2, 2, 0, 0, 1'b1);
      else bus.op_valid = 1'b0;
    end
    check("psum_last_timing", 32'(lastbits), 32'h06);
    check("psum_capture_timing", 32'(psbits), 32'h30);

    // Reset mid-pair with an out_last still travelling through the capture delay.
    @(negedge clk);
    drive_pair(8'h05, 8'h06, 2, 2, 0, 0, 1'b1);
    @(negedge clk);
    check("rstmid_last", 32'(bus.out_last), 32'd1);
    drive_pair(8'hA7, 8'h3C, 3, 3, 0, 0, 1'b1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("rstmid_beat0", 32'(obs_beat()), 32'(vt[1].b[0]));
    @(negedge clk);
    check("rstmid_beat1", 32'(obs_beat()), 32'(vt[1].b[1]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_beat_clear", 32'(obs_beat()), 32'd0);
    check("rstmid_valid_clear", 32'(bus.out_valid), 32'd0);
    check("rstmid_last_clear", 32'(bus.out_last), 32'd0);
    check("rstmid_ready", 32'(bus.op_ready), 32'd1);
    psbits = '0;
    for (int c = 0; c < 6; c++) begin
      psbits[c] = bus.psum_capture;
      @(negedge clk);
    end
    check("rstmid_no_psum", 32'(psbits), 32'd0);
    check("rstmid_idle_after", 32'(bus.out_valid), 32'd0);

    // Random traffic against the beat-list model, with occasional resets.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cur_valid = 1'b0;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exp_last = cur_valid & cur.last;
      check("rnd_valid", 32'(bus.out_valid), 32'(cur_valid));
      check("rnd_beat", 32'(obs_beat()), cur_valid ? 32'(cur.b) : 32'd0);
      check("rnd_last", 32'(bus.out_last), 32'(exp_last));
      check("rnd_ready", 32'(bus.op_ready), 32'(model_q.size() == 0));
      p = pipe.pop_front();
      pipe.push_back(exp_last);
      check("rnd_psum", 32'(bus.psum_capture), 32'(p));

      do_rst = ($urandom_range(0, 299) == 0);
      scramble_inputs();
      bus.op_valid = ($urandom_range(0, 3) != 0);
      rst = do_rst;
      if (do_rst) begin
        model_reset();
        cur_valid = 1'b0;
      end else begin
        if (bus.op_valid && model_q.size() == 0)
          expand(bus.op_in, bus.op_weight, bus.op_in_width, bus.op_weight_width,
                 bus.op_s_in, bus.op_s_weight, bus.op_last);
        cur_valid = (model_q.size() > 0);
        if (cur_valid) cur = model_q.pop_front();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitfusion_operand_feeder.md
Name: bitfusion_operand_feeder

Overview:
Transmit-side sequencer that drives the Bit Fusion top-level operand interface (4-bit in/weight nibbles, width codes, sign flags) one beat per clock. It accepts full 8-bit operand pairs from the operand buffer over a valid/ready handshake. Wide (8-bit) operands are decomposed into 4-bit nibble beats, each tagged with a shift amount. It also emits a psum_capture strobe aligned to the fusion unit's psum output for the last operand of a dot product.

Parameters:
PSUM_LAT, 3, cycles from a beat leaving this block to its contribution being visible on psum (1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  operand pair available
op_ready  output  1  feeder can accept the pair this cycle
op_in  input  8  activation operand
op_weight  input  8  weight operand
op_in_width  input  3  activation width code: 0=1b, 1=2b, 2=4b, 3=8b; 4..7 are treated as 8b
op_weight_width  input  3  weight width code, same encoding as op_in_width
op_s_in  input  1  activation is signed
op_s_weight  input  1  weight is signed
op_last  input  1  final pair of the current dot product
out_valid  output  1  beat on the out_* ports is real
out_in  output  4  activation nibble, to the top-level in port
out_weight  output  4  weight nibble, to the top-level weight port
out_in_width  output  3  per-beat width code, min(code,2)
out_weight_width  output  3  per-beat width code, min(code,2)
out_s_in  output  1  per-beat activation sign flag
out_s_weight  output  1  per-beat weight sign flag
out_shift  output  4  left shift of this beat's product: 0, 4 or 8
out_last  output  1  final beat of an op_last pair
psum_capture  output  1  psum now holds the complete dot-product result

Behaviour:
- All outputs are registered.
- Reset values: out_* = 0, out_valid = 0, out_last = 0, psum_capture = 0, FSM = IDLE.
- op_ready = 1 in IDLE. It is also 1 in the final beat of a multi-beat pair, when a new pair can issue on the next edge. Otherwise op_ready = 0.
- A transfer occurs when op_valid && op_ready.
- Beat count per pair = (in wide ? 2 : 1) * (weight wide ? 2 : 1), giving 1, 2 or 4 beats.
- Beat order for nibble indices (i,w): (0,0), (1,0), (0,1), (1,1), skipping pairs whose operand is narrow. out_shift = 4*(i+w).
- Narrow operand:
  - The nibble is the operand's low 4 bits with bits at or above the width masked to 0. Example: code 1 keeps bits [1:0].
  - The sign flag passes through.
  - The same nibble is repeated on every beat.
- Wide operand:
  - Low nibble is driven with sign flag 0.
  - High nibble is driven with the operand's sign flag.
  - Width code 2 is reported on both beats.
- Latency: a pair accepted at edge t drives its beat 0 after edge t. Remaining beats follow on consecutive edges with no gaps.
- FSM:
  - IDLE: on transfer, go to IDLE if 1 beat, else BEAT.
  - BEAT: a 2-bit beat index advances each cycle.
  - On the final beat: if a transfer occurs, load the new pair and continue back-to-back; else go to IDLE.
- With no pair in flight: out_valid = 0, out_in = out_weight = 0, out_shift = 0. A zero product keeps psum unaffected.
- out_last = 1 only on the final beat of an op_last pair.
- psum_capture:
  - Pulses for 1 cycle exactly PSUM_LAT cycles after out_last was driven high.
  - Implemented as a PSUM_LAT-deep shift register.
  - Back-to-back dot products produce independent pulses.
- Held operand registers are loaded only on a transfer. op_* may change freely when op_ready = 0.
- Reset mid-pair: the pair is abandoned, the FSM returns to IDLE, outputs take reset values, and the capture shift register is cleared, so no stale psum_capture pulse appears.

Decomposition:
- Package bitfusion_feeder_pkg holds:
  - width-code constants W1B=0, W2B=1, W4B=2, W8B=3
  - NIB_W=4
  - the FSM state enum {IDLE, BEAT}
  - function is_wide(code), which returns 1 for codes >= 3
- One combinational sub-module, bitfusion_nibble_slicer. Inputs: operand, width code, sign, nibble index. Outputs: masked nibble, beat width code, beat sign. It is instantiated twice, once for activation and once for weight.

Test Plan:
- 4b x 4b, in=0x0B, w=0x05, codes 2/2, unsigned -> one beat: out_in=B, out_weight=5, shift 0; op_ready stays 1 for back-to-back pairs at 1 pair/cycle.
- 8b x 8b, in=0xA7, w=0x3C -> beats (7,C,0), (A,C,4), (7,3,4), (A,3,8) on 4 consecutive cycles; op_ready low for the first 3 beats.
- Signed 8b x 2b, in=0x80, s_in=1, w=0xFF with code 1, s_w=1 -> beat 0: in nibble 0, s_in=0, weight nibble 3, s_w=1. Beat 1: in nibble 8, s_in=1, weight nibble 3, shift 4.
- PSUM_LAT=3: op_last on a single-beat pair accepted at edge t -> out_last high at t+1 and psum_capture high for exactly one cycle at t+4. Two op_last pairs back-to-back -> two pulses one cycle apart.
- Width masking: in=0xFF with code 0 -> out_in=0x1. Code 6 -> treated as 8b, two beats of F.
- Reset asserted during beat 2 of an 8x8 pair with out_last already in the capture pipe -> next cycle all outputs are 0 and op_ready=1; no psum_capture pulse ever appears.
